// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared types and constants for the word serializer
//
// Purpose: frame geometry, FSM state encoding and the checksum helper
// used by word_serializer.
package word_serializer_pkg;

  localparam int BYTE_W      = 8;
  localparam int NUM_BYTES   = 4;
  localparam int FRAME_CNT_W = 16;
  localparam int FRAME_W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W       = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } state_e;

  // XOR of every byte in a frame; the result is the optional checksum byte.
  function automatic logic [BYTE_W-1:0] xor_bytes(input logic [FRAME_W-1:0] frame);
    logic [BYTE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      acc = acc ^ frame[i*BYTE_W +: BYTE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - four-word frame to valid/ready byte stream serializer
//
// Purpose: captures w, x, y, z from the upstream packer as one frame and
// emits them one byte per cycle (w first), optionally followed by an XOR
// checksum byte. Counts completed frames.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   w, x, y, z        packed words from the upstream packer
//   in_valid/in_ready upstream frame handshake
//   out_data          current byte
//   out_valid/ready   downstream byte handshake
//   out_last          current byte closes the frame
//   frame_count       completed frames, wraps at 16 bits
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter bit APPEND_CSUM = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BYTE_W-1:0]      w,
  input  logic [BYTE_W-1:0]      x,
  input  logic [BYTE_W-1:0]      y,
  input  logic [BYTE_W-1:0]      z,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BYTE_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_W-1:0]     hold_q, hold_d;
  logic [BYTE_W-1:0]      csum_q, csum_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic out_fire;
  logic frame_end;
  logic in_fire;

  // Outputs are decoded from state, so reset (state IDLE, hold cleared)
  // directly yields out_valid/out_last low and out_data 00.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = hold_q[BYTE_W*(NUM_BYTES-1-int'(idx_q)) +: BYTE_W];
        out_last  = (idx_q == LAST_IDX) && !APPEND_CSUM;
      end
      ST_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_fire  = out_valid & out_ready;
  assign frame_end = out_fire & out_last;
  // Accepting at frame end lets back-to-back frames stream with no bubble;
  // this makes in_ready combinationally dependent on out_ready.
  assign in_ready  = (state_q == ST_IDLE) | frame_end;
  assign in_fire   = in_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hold_d        = hold_q;
    csum_d        = csum_q;
    frame_count_d = frame_count_q;

    if (frame_end) begin
      frame_count_d = frame_count_q + 1'b1;
      state_d       = ST_IDLE;
      idx_d         = '0;
    end else if (out_fire && state_q == ST_SEND) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_CSUM;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Capture overrides the frame-end IDLE transition for back-to-back.
    if (in_fire) begin
      hold_d  = {w, x, y, z};
      csum_d  = xor_bytes({w, x, y, z});
      state_d = ST_SEND;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      hold_q        <= '0;
      csum_q        <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      csum_q        <= csum_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - directed self-checking bench for word_serializer
module tb_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  w [2];
  logic [7:0]  x [2];
  logic [7:0]  y [2];
  logic [7:0]  z [2];
  logic        iv [2];
  logic        ir [2];
  logic [7:0]  od [2];
  logic        ov [2];
  logic        ol [2];
  logic        ordy [2];
  logic [15:0] fc [2];

  int vectors = 0;
  int miscompares = 0;

  // index 0: no checksum, index 1: checksum appended
  word_serializer #(.APPEND_CSUM(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .w(w[0]), .x(x[0]), .y(y[0]), .z(z[0]),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]), .out_ready(ordy[0]),
    .frame_count(fc[0])
  );

  word_serializer #(.APPEND_CSUM(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .w(w[1]), .x(x[1]), .y(y[1]), .z(z[1]),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]), .out_ready(ordy[1]),
    .frame_count(fc[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_frame(input int k, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic v);
    w[k] = a; x[k] = b; y[k] = c; z[k] = d; iv[k] = v;
  endtask

  // Checks the byte currently presented, then advances to the next negedge.
  task automatic expect_byte(input int k, input string tag, input logic [7:0] d, input logic last);
    check({tag, "_valid"}, 32'(ov[k]), 32'd1);
    check({tag, "_data"},  32'(od[k]), 32'(d));
    check({tag, "_last"},  32'(ol[k]), 32'(last));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_frame(k, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      ordy[k] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d_valid", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst%0d_last", k),  32'(ol[k]), 32'd0);
      check($sformatf("rst%0d_data", k),  32'(od[k]), 32'h00);
      check($sformatf("rst%0d_fc", k),    32'(fc[k]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rst_ready0", 32'(ir[0]), 32'd1);
    check("rst_ready1", 32'(ir[1]), 32'd1);
    @(negedge clk);

    // single frame with checksum
    set_frame(1, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1);
    check("t1_in_ready", 32'(ir[1]), 32'd1);
    @(negedge clk);
    iv[1] = 1'b0;
    check("t1_busy_ready", 32'(ir[1]), 32'd0);
    expect_byte(1, "t1_b0", 8'hA5, 1'b0);
    expect_byte(1, "t1_b1", 8'h3C, 1'b0);
    expect_byte(1, "t1_b2", 8'h0F, 1'b0);
    expect_byte(1, "t1_b3", 8'hF0, 1'b0);
    check("t1_end_ready", 32'(ir[1]), 32'd1);
    expect_byte(1, "t1_b4", 8'h66, 1'b1);
    check("t1_idle_valid", 32'(ov[1]), 32'd0);
    check("t1_fc", 32'(fc[1]), 32'd1);

    // single frame without checksum
    set_frame(0, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1);
    @(negedge clk);
    iv[0] = 1'b0;
    check("t2_busy_ready", 32'(ir[0]), 32'd0);
    expect_byte(0, "t2_b0", 8'hA5, 1'b0);
    expect_byte(0, "t2_b1", 8'h3C, 1'b0);
    expect_byte(0, "t2_b2", 8'h0F, 1'b0);
    check("t2_end_ready", 32'(ir[0]), 32'd1);
    expect_byte(0, "t2_b3", 8'hF0, 1'b1);
    check("t2_idle_valid", 32'(ov[0]), 32'd0);
    check("t2_fc", 32'(fc[0]), 32'd1);

    // downstream stall on byte 3C
    set_frame(1, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1);
    @(negedge clk);
    iv[1] = 1'b0;
    expect_byte(1, "t3_b0", 8'hA5, 1'b0);
    ordy[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_stall%0d_data", i),  32'(od[1]), 32'h3C);
      check($sformatf("t3_stall%0d_valid", i), 32'(ov[1]), 32'd1);
      check($sformatf("t3_stall%0d_last", i),  32'(ol[1]), 32'd0);
      check($sformatf("t3_stall%0d_ready", i), 32'(ir[1]), 32'd0);
      @(negedge clk);
    end
    ordy[1] = 1'b1;
    expect_byte(1, "t3_b1", 8'h3C, 1'b0);
    expect_byte(1, "t3_b2", 8'h0F, 1'b0);
    expect_byte(1, "t3_b3", 8'hF0, 1'b0);
    expect_byte(1, "t3_b4", 8'h66, 1'b1);
    check("t3_fc", 32'(fc[1]), 32'd2);

    // back-to-back frames with in_valid held high
    set_frame(1, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1);
    @(negedge clk);
    set_frame(1, 8'h01, 8'h02, 8'h04, 8'h08, 1'b1);
    expect_byte(1, "t4_a0", 8'hA5, 1'b0);
    expect_byte(1, "t4_a1", 8'h3C, 1'b0);
    expect_byte(1, "t4_a2", 8'h0F, 1'b0);
    expect_byte(1, "t4_a3", 8'hF0, 1'b0);
    check("t4_end_ready", 32'(ir[1]), 32'd1);
    expect_byte(1, "t4_a4", 8'h66, 1'b1);
    iv[1] = 1'b0;
    expect_byte(1, "t4_b0", 8'h01, 1'b0);
    expect_byte(1, "t4_b1", 8'h02, 1'b0);
    expect_byte(1, "t4_b2", 8'h04, 1'b0);
    expect_byte(1, "t4_b3", 8'h08, 1'b0);
    expect_byte(1, "t4_b4", 8'h0F, 1'b1);
    check("t4_idle_valid", 32'(ov[1]), 32'd0);
    check("t4_fc", 32'(fc[1]), 32'd4);

    // asynchronous reset mid-frame
    set_frame(1, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1);
    @(negedge clk);
    iv[1] = 1'b0;
    expect_byte(1, "t5_b0", 8'hA5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(ov[1]), 32'd0);
    check("t5_rst_data",  32'(od[1]), 32'h00);
    check("t5_rst_last",  32'(ol[1]), 32'd0);
    check("t5_rst_fc",    32'(fc[1]), 32'd0);
    check("t5_rst_fc0",   32'(fc[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_frame(1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    @(negedge clk);
    iv[1] = 1'b0;
    expect_byte(1, "t5_b0n", 8'h11, 1'b0);
    expect_byte(1, "t5_b1n", 8'h22, 1'b0);
    expect_byte(1, "t5_b2n", 8'h33, 1'b0);
    expect_byte(1, "t5_b3n", 8'h44, 1'b0);
    expect_byte(1, "t5_b4n", 8'h44, 1'b1);
    check("t5_fc", 32'(fc[1]), 32'd1);

    // frame counter wrap
    force u_dut1.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release u_dut1.frame_count_q;
    check("t6_preload", 32'(fc[1]), 32'hFFFF);
    set_frame(1, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1);
    @(negedge clk);
    iv[1] = 1'b0;
    expect_byte(1, "t6_b0", 8'hA5, 1'b0);
    expect_byte(1, "t6_b1", 8'h3C, 1'b0);
    expect_byte(1, "t6_b2", 8'h0F, 1'b0);
    expect_byte(1, "t6_b3", 8'hF0, 1'b0);
    check("t6_pre_wrap", 32'(fc[1]), 32'hFFFF);
    expect_byte(1, "t6_b4", 8'h66, 1'b1);
    check("t6_wrap", 32'(fc[1]), 32'h0000);
    check("t6_idle_valid", 32'(ov[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
